// File: rtl/col_id_dispatch_if.sv
// rtl/col_id_dispatch_if.sv - column-id stream input and per-channel FIFO head/pop bundle
interface col_id_dispatch_if #(
    parameter int channel_num = 4,
    parameter int col_id_size = 10
);
    logic [col_id_size-1:0]             in_id;
    logic                               in_valid;
    logic                               in_last;
    logic                               in_ready;
    logic [channel_num*col_id_size-1:0] id;
    logic [channel_num-1:0]             id_fifo_empty;
    logic [channel_num-1:0]             id_fifo_read;
    logic                               busy;

    modport master (
        output in_id, in_valid, in_last, id_fifo_read,
        input  in_ready, id, id_fifo_empty, busy
    );

    modport slave (
        input  in_id, in_valid, in_last, id_fifo_read,
        output in_ready, id, id_fifo_empty, busy
    );
endinterface

// File: rtl/col_id_dispatch.sv
// rtl/col_id_dispatch.sv - deals a column-id stream round-robin into per-channel show-ahead FIFOs
module col_id_dispatch #(
    parameter int channel_num     = 4,
    parameter int col_id_size     = 10,
    parameter int fifo_depth_bits = 3
) (
    input logic               clk,
    input logic               rst,
    col_id_dispatch_if.slave  bus
);
    localparam int depth    = 1 << fifo_depth_bits;
    localparam int ptr_bits = (channel_num > 1) ? $clog2(channel_num) : 1;
    localparam logic [ptr_bits-1:0] last_ch = ptr_bits'(channel_num - 1);

    logic [ptr_bits-1:0]    ptr;
    logic [channel_num-1:0] full;
    logic [channel_num-1:0] empty;
    logic [channel_num-1:0] wr_en;
    logic [channel_num-1:0] rd_en;
    logic [col_id_size-1:0] head [channel_num];
    logic                   accept;

    // Only the target FIFO gates input, so ids are never reordered across channels.
    assign bus.in_ready      = ~full[ptr];
    assign accept            = bus.in_valid & bus.in_ready;
    assign bus.id_fifo_empty = empty;
    assign bus.busy          = ~&empty;

    always_comb begin
        bus.id = '0;
        for (int c = 0; c < channel_num; c++) begin
            bus.id[c*col_id_size +: col_id_size] = head[c];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (accept) begin
            if (bus.in_last || ptr == last_ch) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    for (genvar c = 0; c < channel_num; c++) begin : g_fifo
        logic [fifo_depth_bits:0] wr_ptr;
        logic [fifo_depth_bits:0] rd_ptr;
        logic [col_id_size-1:0]   mem [depth];

        assign empty[c] = (wr_ptr == rd_ptr);
        assign full[c]  = (wr_ptr[fifo_depth_bits-1:0] == rd_ptr[fifo_depth_bits-1:0]) &&
                          (wr_ptr[fifo_depth_bits] != rd_ptr[fifo_depth_bits]);
        assign wr_en[c] = accept && (ptr == ptr_bits'(c));
        assign rd_en[c] = bus.id_fifo_read[c] & ~empty[c];
        // Zero the head when empty so unreset memory contents never leak out.
        assign head[c]  = empty[c] ? '0 : mem[rd_ptr[fifo_depth_bits-1:0]];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en[c]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_en[c]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (wr_en[c]) begin
                mem[wr_ptr[fifo_depth_bits-1:0]] <= bus.in_id;
            end
        end
    end
endmodule

// File: doc/col_id_dispatch.md
# col_id_dispatch

Write side of the column-id FIFO interface consumed by `bvb`. Accepts one serial stream of column ids from the sparse-matrix reader and deals them round-robin into `channel_num` show-ahead FIFOs, one per channel. `bvb` pops the FIFOs through the `id` / `id_fifo_empty` / `id_fifo_read` interface. Row boundaries realign the deal so every row starts on channel 0.

## Interface
Parameters:
- `channel_num`, 4: number of channels and FIFOs.
- `col_id_size`, 10: column id width.
- `fifo_depth_bits`, 3: log2 of the per-channel FIFO depth (depth 8).

Ports:
- `clk`  in  1: the single clock; all logic is rising-edge.
- `rst`  in  1: asynchronous, active-low reset. Asserting it clears all state immediately; release is sampled on `clk`.
- `in_id`  in  `col_id_size`: incoming column id.
- `in_valid`  in  1: `in_id` is valid.
- `in_last`  in  1: `in_id` is the last id of a matrix row. Qualified by `in_valid`.
- `in_ready`  out  1: the dispatcher can accept `in_id` this cycle.
- `id`  out  `channel_num*col_id_size`: head word of each FIFO. Channel c occupies bits [c*col_id_size +: col_id_size].
- `id_fifo_empty`  out  `channel_num`: per-channel empty flag.
- `id_fifo_read`  in  `channel_num`: per-channel pop request.
- `busy`  out  1: high while any FIFO holds data.

## Operation
- Word transfer: a word is accepted when `in_valid & in_ready` at a rising edge.
- Dealing pointer `ptr` (0..channel_num-1):
  - The accepted word is written to FIFO[`ptr`].
  - `ptr` then becomes 0 if `in_last` is high, otherwise `(ptr+1) mod channel_num`.
- Ordering: words are never skipped or reordered. `in_ready = ~full[ptr]`, so if the target FIFO is full, input stalls even when other FIFOs have space.
- FIFO structure: each FIFO has a write pointer and a read pointer, each `fifo_depth_bits`+1 wide, with the MSB used as a wrap bit.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
  - Pointers wrap modulo 2*depth.
- Show-ahead output: `id` slice c always presents `mem_c[rd_ptr_c]` when FIFO c is non-empty. The slice is forced to 0 when FIFO c is empty.
- Pops:
  - `id_fifo_read[c]` while FIFO c is empty is ignored: no pointer change, no error.
  - A pop and a write to the same FIFO in the same cycle are both performed, provided it is not empty and not full respectively.
  - A write into a full FIFO cannot occur because `in_ready` gates it. `in_ready` does not depend combinationally on `id_fifo_read`, so a simultaneous pop does not rescue a full FIFO in that cycle.
- `busy = ~&id_fifo_empty`.
- Reset values (while `rst` is low):
  - `ptr = 0`; all FIFO pointers are 0.
  - `id_fifo_empty` all ones; `id` all zeros; `busy = 0`; `in_ready = 1`.
  - FIFO memory is not reset.
  - Reset asserted mid-stream discards all queued ids.

## Timing
- Write-to-visible latency is 1 cycle. A word accepted at edge t drives `id_fifo_empty[c]` low and appears on `id` slice c after edge t.
- A pop at edge t advances the head: the next word, or empty=1 plus a zero slice, is visible after edge t. Back-to-back pops every cycle are supported.
- `in_ready` updates after each edge from the registered pointers plus `ptr`. Full throughput is one accepted id per cycle while the target FIFO has space.
- A FIFO that goes empty→write→pop sustains one word per cycle with no bubble.
- `in_last` takes effect for the next accepted word. `in_last` held on consecutive accepts keeps writing channel 0.

## Test plan
- Reset and idle: hold `rst` low, then release with no input. Required: `id_fifo_empty=4'b1111`, `id=0`, `in_ready=1`, `busy=0`.
- Round-robin deal with 1-cycle visibility:
  - Stimulus: send ids 0, 128, 255, 254 (no `in_last`), no pops.
  - Required: `id` = {254, 255, 128, 0} (channel 3 down to channel 0), empty=0 one cycle after the fourth accept.
  - Then pop all four together: next cycle empty=4'b1111, `id=0`.
- Row realign:
  - Stimulus: send 1022 (`in_last`=1), 1023, 511.
  - Required: 1022 and 1023 both land in channel 0; 511 lands in channel 1; channels 2 and 3 stay empty.
- Full stall and wrap:
  - Stimulus: with `in_last` held high, send 9 ids (1..9) into channel 0 with no pops.
  - Required: `in_ready` drops after the 8th accept and id 9 waits.
  - Then pop channel 0 once. Required: `in_ready` rises the next cycle and 9 is accepted.
  - Drain: required order is 2..9, exercising pointer wrap.
- Simultaneous events and mid-operation reset:
  - Pop an empty channel while writing it. Required: the word is retained and empty goes 0.
  - Pop and write a half-full FIFO in the same cycle. Required: occupancy is unchanged.
  - Assert `rst` with 3 words queued. Required: outputs return to reset values immediately, asynchronously, and no stale id is ever presented afterward.
